// File: rtl/aes_dec_pipe_kx.sv
// AES inverse-cipher pipeline (128/256-bit keys) with a loadable round-key store.
// One block per cycle, NR+1 register stages, a tag carried alongside each block.
module aes_dec_pipe_kx #(
  parameter int KEY_LENGTH = 128,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             rk_valid,
  input  logic [3:0]       rk_idx,
  input  logic [127:0]     rk_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             keys_valid,
  output logic             key_err
);

  localparam int         NR     = KEY_LENGTH / 32 + 6;
  localparam logic [3:0] NR_IDX = 4'(NR);
  localparam int         OW     = $clog2(NR + 2);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [NR:0]      mask_q, mask_d;
  logic             key_err_q, key_err_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             rk_we;
  logic             accept;
  logic             retire;

  logic [127:0]     rk_q  [NR+1];
  logic [127:0]     st_q  [NR+1];
  logic [127:0]     st_d  [NR+1];
  logic [TAG_W-1:0] tag_q [NR+1];
  logic [NR:0]      vld_q;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte n of the state sits at bits [127-8n -: 8], column-major (n = row + 4*col).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign keys_valid = (state_q == RUN);
  assign in_ready   = (state_q == RUN) && !load_start;
  assign accept     = in_valid && in_ready;
  assign retire     = vld_q[NR];
  assign key_err    = key_err_q;
  assign out_valid  = vld_q[NR];
  assign out_data   = vld_q[NR] ? st_q[NR]  : '0;
  assign out_tag    = vld_q[NR] ? tag_q[NR] : '0;

  // Inverse rounds regrouped so each stage ends on InvSubBytes: the key add and
  // InvMixColumns of round r open the stage that follows it.
  always_comb begin
    st_d[0] = inv_sub_bytes(inv_shift_rows(in_data ^ rk_q[NR]));
    for (int unsigned i = 1; i < NR; i++)
      st_d[i] = inv_sub_bytes(inv_shift_rows(inv_mix_columns(st_q[i-1] ^ rk_q[NR-i])));
    st_d[NR] = st_q[NR-1] ^ rk_q[0];
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    key_err_d = load_start ? 1'b0 : key_err_q;
    rk_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        mask_d = '0;
        if (load_start) state_d = LOAD;
      end
      LOAD: begin
        if (load_start) begin
          mask_d = '0;
        end else if (rk_valid) begin
          if (rk_idx <= NR_IDX) begin
            rk_we          = 1'b1;
            mask_d[rk_idx] = 1'b1;
          end else begin
            key_err_d = 1'b1;
          end
        end
        if (!load_start && (&mask_d)) state_d = RUN;
      end
      RUN: begin
        mask_d = '0;
        if (load_start) state_d = (occ_q == '0) ? LOAD : DRAIN;
      end
      DRAIN: begin
        mask_d = '0;
        if (occ_q == '0) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({accept, retire})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      key_err_q <= 1'b0;
      occ_q     <= '0;
      vld_q     <= '0;
      for (int unsigned i = 0; i <= NR; i++) begin
        rk_q[i]  <= '0;
        st_q[i]  <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      key_err_q <= key_err_d;
      occ_q     <= occ_d;
      vld_q     <= {vld_q[NR-1:0], accept};
      if (rk_we) rk_q[rk_idx] <= rk_data;
      tag_q[0] <= in_tag;
      for (int unsigned i = 0; i <= NR; i++) st_q[i] <= st_d[i];
      for (int unsigned i = 1; i <= NR; i++) tag_q[i] <= tag_q[i-1];
    end
  end

endmodule
